// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shift/rotate unit, STEP bits per clock, valid/ready on both sides
module iter_shifter #(
    parameter int WIDTH   = 16,
    parameter int STEP    = 2,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_oper,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_t             state, state_next;
    logic [WIDTH-1:0]   data_q, step_data;
    logic [SHAMT_W-1:0] rem_q, rem_next, k;
    logic [2:0]         oper_q;
    logic               err_q;
    logic               illegal;

    assign illegal  = (in_oper > 3'b100);
    assign k        = (rem_q > STEP_K) ? STEP_K : rem_q;
    assign rem_next = rem_q - k;

    // One iteration of at most STEP bits; SRA re-samples the current MSB each step
    always_comb begin
        step_data = data_q;
        case (oper_q)
            3'b000:  step_data = (data_q << k) | (data_q >> (WIDTH - int'(k)));
            3'b001:  step_data = data_q << k;
            3'b010:  step_data = $unsigned($signed(data_q) >>> k);
            3'b011:  step_data = data_q >> k;
            3'b100:  step_data = (data_q >> k) | (data_q << (WIDTH - int'(k)));
            default: step_data = data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (illegal || in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            rem_q  <= '0;
            oper_q <= 3'b000;
            err_q  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            data_q <= in_data;
            rem_q  <= illegal ? '0 : in_shamt;
            oper_q <= in_oper;
            err_q  <= illegal;
        end else if (state == SHIFT) begin
            data_q <= step_data;
            rem_q  <= rem_next;
        end
    end

    assign out_data = data_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed bench for iter_shifter at STEP 2 (timed) plus STEP 1 and 4 instances
module tb_iter_shifter;

    localparam int WIDTH = 16;
    localparam int SW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [SW-1:0]    in_shamt = '0;
    logic [2:0]       in_oper = 3'b000;
    logic             out_ready = 1'b0;

    logic             rdy2, rdy1, rdy4;
    logic             vld2, vld1, vld4;
    logic [WIDTH-1:0] dat2, dat1, dat4;
    logic             err2, err1, err4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(WIDTH), .STEP(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_shamt(in_shamt), .in_oper(in_oper),
        .out_valid(vld2), .out_ready(out_ready), .out_data(dat2), .out_err(err2)
    );

    iter_shifter #(.WIDTH(WIDTH), .STEP(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_shamt(in_shamt), .in_oper(in_oper),
        .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .out_err(err1)
    );

    iter_shifter #(.WIDTH(WIDTH), .STEP(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .in_shamt(in_shamt), .in_oper(in_oper),
        .out_valid(vld4), .out_ready(out_ready), .out_data(dat4), .out_err(err4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request to all instances, time the STEP=2 one, then complete the handshake
    task automatic run_req(input string tag, input logic [2:0] oper, input logic [15:0] data,
                           input logic [3:0] shamt, input logic [15:0] exp,
                           input logic exp_err, input int exp_lat);
        int lat;
        int wait_cnt;
        in_valid = 1'b1;
        in_oper  = oper;
        in_data  = data;
        in_shamt = shamt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!vld2 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " s2 data"}, dat2, exp);
        check_eq({tag, " s2 err"}, err2, exp_err);
        wait_cnt = 0;
        while (!(vld1 && vld4) && wait_cnt < 40) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check_eq({tag, " s1/s4 valid"}, {vld1, vld4}, 2'b11);
        check_eq({tag, " s1 data"}, dat1, exp);
        check_eq({tag, " s4 data"}, dat4, exp);
        check_eq({tag, " s1/s4 err"}, {err1, err4}, {exp_err, exp_err});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " back to idle"}, {rdy2, rdy1, rdy4, vld2}, 4'b1110);
    endtask

    initial begin
        #2;
        check_eq("reset in_ready", rdy2, 1'b1);
        check_eq("reset out_valid", vld2, 1'b0);
        check_eq("reset out_data", dat2, 16'h0000);
        check_eq("reset out_err", err2, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_req("rol1",   3'b000, 16'h8001, 4'd1,  16'h0003, 1'b0, 1);
        run_req("sra15",  3'b010, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 8);
        run_req("srl15",  3'b011, 16'h8000, 4'd15, 16'h0001, 1'b0, 8);
        run_req("sll0",   3'b001, 16'hFFFF, 4'd0,  16'hFFFF, 1'b0, 0);
        run_req("ror4",   3'b100, 16'h0001, 4'd4,  16'h1000, 1'b0, 2);
        run_req("ill111", 3'b111, 16'h1234, 4'd7,  16'h1234, 1'b1, 0);
        run_req("ill101", 3'b101, 16'hBEEF, 4'd0,  16'hBEEF, 1'b1, 0);
        run_req("sll5",   3'b001, 16'h00F3, 4'd5,  16'h1E60, 1'b0, 3);
        run_req("sra3",   3'b010, 16'h7F00, 4'd3,  16'h0FE0, 1'b0, 2);
        run_req("rol8",   3'b000, 16'h1234, 4'd8,  16'h3412, 1'b0, 4);
        run_req("ror3",   3'b100, 16'h8421, 4'd3,  16'h3084, 1'b0, 2);
        run_req("sra9",   3'b010, 16'hA5A5, 4'd9,  16'hFFD2, 1'b0, 5);
        run_req("srl9",   3'b011, 16'hA5A5, 4'd9,  16'h0052, 1'b0, 5);

        // Backpressure: result held in DONE while a competing request is presented
        in_valid = 1'b1;
        in_oper  = 3'b001;
        in_data  = 16'h0003;
        in_shamt = 4'd2;
        @(posedge clk);
        #1;
        in_data  = 16'hAAAA;
        in_shamt = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("bp out_valid", vld2, 1'b1);
            check_eq("bp out_data", dat2, 16'h000C);
            check_eq("bp in_ready", rdy2, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp release idle", {rdy2, vld2}, 2'b10);

        // Reset in the middle of a long shift
        in_valid = 1'b1;
        in_oper  = 3'b001;
        in_data  = 16'h0001;
        in_shamt = 4'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("rst mid in_ready", {rdy2, rdy1, rdy4}, 3'b111);
        check_eq("rst mid out_valid", {vld2, vld1, vld4}, 3'b000);
        check_eq("rst mid out_data", dat2, 16'h0000);
        check_eq("rst mid out_err", err2, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_req("sll13", 3'b001, 16'h0001, 4'd13, 16'h2000, 1'b0, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
